// File: rtl/gated_toggle_pkg.sv
// rtl/gated_toggle_pkg.sv - shared mode type and constants for the gated toggle array
// Purpose: defines the 2-bit update-function select used by every channel.
// Ports: none (package).
package gated_toggle_pkg;

  typedef enum logic [1:0] {
    LEGACY  = 2'd0,
    CAPTURE = 2'd1,
    TOGGLE  = 2'd2,
    HOLD    = 2'd3
  } mode_e;

endpackage

// File: rtl/gated_toggle_cell.sv
// rtl/gated_toggle_cell.sv - single-channel core state bit with mode-selected update
// Purpose: holds one channel's core state q and applies the selected update
//          function on qualified cycles.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   upd    - qualified cycle (in_valid & en)
//   a, b   - channel operands; gate term g = a & b
//   mode   - update function select
//   q      - current core state
//   q_next - state that will be loaded on the next edge
module gated_toggle_cell
  import gated_toggle_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  upd,
  input  logic  a,
  input  logic  b,
  input  mode_e mode,
  output logic  q,
  output logic  q_next
);

  logic q_q;
  logic q_d;
  logic g;

  always_comb begin
    g   = a & b;
    q_d = q_q;
    if (upd) begin
      case (mode)
        LEGACY:  q_d = g & ~q_q;
        CAPTURE: q_d = g;
        TOGGLE:  q_d = q_q ^ g;
        HOLD:    q_d = q_q;
        default: q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign q_next = q_d;

endmodule

// File: rtl/gated_toggle_array.sv
// rtl/gated_toggle_array.sv - WIDTH-channel gated toggle array with output pipeline and rise counter
// Purpose: WIDTH independent core state bits updated on qualified cycles,
//          delayed through a DEPTH-stage output pipeline with a matching valid
//          chain, plus a saturating count of cycles on which any core bit rises.
// Ports:
//   iccad_clk   - clock, rising edge
//   iccad_rst_n - asynchronous active-low reset
//   inp1, inp2  - per-channel operands
//   in_valid    - operands qualified this cycle
//   en          - global update enable
//   mode        - update function select
//   clr         - synchronous clear of rise_cnt
//   out         - core state after DEPTH cycles of latency
//   out_valid   - out carries the result of a qualified update
//   rise_cnt    - saturating count of cycles with any core 0->1 transition
module gated_toggle_array
  import gated_toggle_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             iccad_clk,
  input  logic             iccad_rst_n,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic             in_valid,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [CNT_W-1:0] rise_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             qual;
  mode_e            mode_sel;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_d;
  logic             rise;

  assign qual     = in_valid & en;
  assign mode_sel = mode_e'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gated_toggle_cell u_cell (
      .clk    (iccad_clk),
      .rst_n  (iccad_rst_n),
      .upd    (qual),
      .a      (inp1[i]),
      .b      (inp2[i]),
      .mode   (mode_sel),
      .q      (core_q[i]),
      .q_next (core_d[i])
    );
  end

  // One increment per cycle no matter how many bits rise together.
  assign rise = |(core_d & ~core_q);

  // Valid chain: bit 0 tracks the core stage, bit DEPTH-1 is the output stage.
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;

  always_comb begin
    vld_d    = vld_q;
    vld_d[0] = qual;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];

  // Data stages after the core advance unconditionally; out_valid qualifies them.
  if (DEPTH > 1) begin : g_pipe
    logic [WIDTH-1:0] pipe_q [DEPTH-1];
    logic [WIDTH-1:0] pipe_d [DEPTH-1];

    always_comb begin
      pipe_d[0] = core_q;
      for (int i = 1; i < DEPTH - 1; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
      if (!iccad_rst_n) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign out = pipe_q[DEPTH-2];
  end else begin : g_direct
    assign out = core_q;
  end

  // Saturating rise counter; clear takes priority over an increment.
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rise_cnt = cnt_q;

endmodule

// File: tb/tb_gated_toggle_array.sv
// tb/tb_gated_toggle_array.sv - self-checking bench for gated_toggle_array
module tb_gated_toggle_array;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic             in_valid;
  logic             en;
  logic [1:0]       mode;
  logic             clr;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic [CNT_W-1:0] rise_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: current core value, history of core values/valids
  // (newest first) and the counter as a plain integer.
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_dq[$];
  logic             m_vq[$];
  int               m_cnt;

  gated_toggle_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .iccad_clk   (clk),
    .iccad_rst_n (rst_n),
    .inp1        (inp1),
    .inp2        (inp2),
    .in_valid    (in_valid),
    .en          (en),
    .mode        (mode),
    .clr         (clr),
    .out         (out),
    .out_valid   (out_valid),
    .rise_cnt    (rise_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q   = '0;
    m_cnt = 0;
    m_dq.delete();
    m_vq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_dq.push_back('0);
      m_vq.push_back(1'b0);
    end
  endtask

  task automatic model_step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic v, input logic e, input logic [1:0] m, input logic c);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] nq;
    logic             q_ok;
    g    = a & b;
    q_ok = v && e;
    nq   = m_q;
    if (q_ok) begin
      if (m == 2'd0)      nq = g & ~m_q;
      else if (m == 2'd1) nq = g;
      else if (m == 2'd2) nq = m_q ^ g;
      else                nq = m_q;
    end
    if (c)                                  m_cnt = 0;
    else if (((nq & ~m_q) != 0) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    m_q = nq;
    m_dq.push_front(nq);
    void'(m_dq.pop_back());
    m_vq.push_front(q_ok);
    void'(m_vq.pop_back());
  endtask

  task automatic check_model();
    chk("out", 32'(out), 32'(m_dq[DEPTH-1]));
    chk("out_valid", 32'(out_valid), 32'(m_vq[DEPTH-1]));
    chk("rise_cnt", 32'(rise_cnt), 32'(m_cnt));
  endtask

  // Called at a negedge; drives inputs, clocks once, checks at the next negedge.
  task automatic cyc(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic v, input logic e, input logic [1:0] m, input logic c);
    inp1 = a; inp2 = b; in_valid = v; en = e; mode = m; clr = c;
    @(posedge clk);
    model_step(a, b, v, e, m, c);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    inp1 = '0; inp2 = '0; in_valid = 1'b0; en = 1'b0; mode = 2'd0; clr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int exp_cnt[4] = '{1, 1, 2, 2};

  initial begin
    rst_n = 1'b1;
    inp1 = '0; inp2 = '0; in_valid = 1'b0; en = 1'b0; mode = 2'd0; clr = 1'b0;
    @(negedge clk);

    // Reset state
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_rise_cnt", 32'(rise_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Capture 0xA & 0xC, one qualified cycle
    cyc(4'hA, 4'hC, 1'b1, 1'b1, 2'd1, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("capture_out", 32'(out), 32'h8);
    chk("capture_valid", 32'(out_valid), 32'h1);
    cyc(4'h0, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("capture_valid_drop", 32'(out_valid), 32'h0);

    // Legacy mode, all ones every cycle: rise count 1,1,2,2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b0);
      chk("legacy_cnt", 32'(rise_cnt), 32'(exp_cnt[i]));
    end
    chk("legacy_out", 32'(out), 32'hF);

    // Toggle g=3 three times, then hold with g=F
    do_reset();
    repeat (3) cyc(4'h3, 4'h3, 1'b1, 1'b1, 2'd2, 1'b0);
    repeat (3) cyc(4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 1'b0);
    chk("hold_out", 32'(out), 32'h3);
    chk("hold_valid", 32'(out_valid), 32'h1);

    // en low with in_valid high after q=5
    do_reset();
    cyc(4'h5, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0);
    cyc(4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 1'b0);
    chk("en_drop_valid_still", 32'(out_valid), 32'h1);
    cyc(4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 1'b0);
    chk("en_drop_valid_fall", 32'(out_valid), 32'h0);
    repeat (2) cyc(4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 1'b0);
    chk("en_drop_out", 32'(out), 32'h5);
    chk("en_drop_cnt", 32'(rise_cnt), 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
          2'($urandom), 1'($urandom_range(0, 15) == 0));
    end

    // Reset pulse mid-stream with out_valid high
    cyc(4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0);
    cyc(4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0);
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_out", 32'(out), 32'h0);
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_cnt", 32'(rise_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'h6, 4'hF, 1'b1, 1'b1, 2'd2, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0, 2'd2, 1'b0);
    chk("post_reset_out", 32'(out), 32'h6);

    // Saturation: alternating capture patterns give a rise every cycle
    do_reset();
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      cyc((i % 2 == 0) ? 4'h1 : 4'h2, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0);
    end
    chk("sat_cnt", 32'(rise_cnt), 32'hFFFF);
    cyc(4'h1, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1);
    chk("clr_on_rise", 32'(rise_cnt), 32'h0);
    cyc(4'h2, 4'hF, 1'b1, 1'b1, 2'd1, 1'b0);
    chk("after_clr", 32'(rise_cnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gated_toggle_array.md
GATED_TOGGLE_ARRAY -- requirements
Module: gated_toggle_array

Interface
REQ-001 Parameter WIDTH, default 4, number of independent channels (>=1).
REQ-002 Parameter DEPTH, default 2, number of output register stages including the core state stage (>=1).
REQ-003 Parameter CNT_W, default 16, width of the rise-event counter.
REQ-004 iccad_clk  input  1  sole clock; all state rises on posedge.
REQ-005 iccad_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 inp1  input  WIDTH  per-channel operand A.
REQ-007 inp2  input  WIDTH  per-channel operand B.
REQ-008 in_valid  input  1  operands qualified this cycle.
REQ-009 en  input  1  global update enable.
REQ-010 mode  input  2  update function select.
REQ-011 clr  input  1  synchronous clear of rise_cnt.
REQ-012 out  output  WIDTH  core state delayed through the output pipeline.
REQ-013 out_valid  output  1  out carries the result of a qualified update.
REQ-014 rise_cnt  output  CNT_W  saturating count of cycles with any core 0->1 transition.

Function
REQ-015 Qualified cycle is in_valid=1 and en=1; on a non-qualified cycle core state q[WIDTH] holds.
REQ-016 Per channel, with g = inp1 & inp2, on a qualified cycle: mode 0 (LEGACY) q <= g & ~q; mode 1 (CAPTURE) q <= g; mode 2 (TOGGLE) q <= q ^ g; mode 3 (HOLD) q <= q.
REQ-017 Mode change takes effect on the next qualified cycle; it does not clear q.
REQ-018 q is pipeline stage 1; stages 2..DEPTH are plain registers; out = stage DEPTH; total latency from sampled inputs to out is DEPTH cycles.
REQ-019 Valid pipeline: stage-1 valid <= qualified cycle (independent of mode, HOLD included); it shifts in lockstep with data; out_valid = stage-DEPTH valid.
REQ-020 Data stages 2..DEPTH advance every cycle regardless of en/in_valid; out_valid alone marks meaningful data.
REQ-021 rise_cnt increments by 1 on any cycle where at least one bit of q goes 0->1 (one increment regardless of bit count).
REQ-022 rise_cnt saturates at 2^CNT_W-1 and never wraps.
REQ-023 clr=1 sets rise_cnt to 0 next edge; clr wins over a simultaneous increment.
REQ-024 DEPTH=1: out is q directly from the register, latency 1.

Reset
REQ-025 iccad_rst_n low asynchronously forces q, all pipeline stages, all valid bits and rise_cnt to 0; out=0, out_valid=0, rise_cnt=0 while asserted.
REQ-026 Reset mid-operation discards in-flight data; first qualified cycle after release behaves as from q=0.
REQ-027 Reset deassertion is synchronised externally; no internal synchroniser.

Structure
REQ-028 Shared package gated_toggle_pkg holds the 2-bit mode type and constants LEGACY=0, CAPTURE=1, TOGGLE=2, HOLD=3.
REQ-029 One sub-module gated_toggle_cell implements a single channel's core state and REQ-016 update; instantiated WIDTH times; pipeline, valid chain and counter live in the top.

Verification
REQ-030 WIDTH=4, DEPTH=2, mode 1, inp1=4'hA, inp2=4'hC, one qualified cycle -> out=4'h8, out_valid=1 exactly 2 cycles later, out_valid=0 the cycle after.
REQ-031 Mode 0, inp1=inp2=4'hF, qualified every cycle from reset -> q sequence F,0,F,0; out lags by one further cycle; rise_cnt increments every other cycle (1,1,2,2,...).
REQ-032 Mode 2, g=4'h3 for 3 qualified cycles from q=0 -> q=3,0,3; then mode 3 with g=4'hF -> q stays 3, out_valid still 1.
REQ-033 en=0 with in_valid=1 for 4 cycles after q=4'h5 -> q holds 5, out_valid falls to 0 two cycles after en drops, rise_cnt unchanged.
REQ-034 Mode 0 toggling beyond 2^16 rises -> rise_cnt holds 16'hFFFF; clr asserted on a rise cycle -> rise_cnt=0 next cycle.
REQ-035 iccad_rst_n pulsed low mid-stream with out_valid=1 -> out, out_valid, rise_cnt read 0 before the next clock edge.
